// File: rtl/mul_div_iterativo.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide, one bit per clock.
// Optional MD_EARLY_OUT_EN: zero-operand cases bypass the iteration loop and go straight to FIX.
//
// state  | meaning
// IDLE   | waiting for start; operands, magnitudes and sign flags latched on accept
// CALC   | 32 iterations, one multiply/divide bit per edge
// FIX    | sign correction, word select, divide-by-zero override; registers result
// DONE   | done pulse for one cycle, then back to IDLE
module mul_div_iterativo #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            reset_MD,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic [4:0]          rd_q, rd_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opb_q, opb_d;
    logic [XLEN-1:0]     a_orig_q, a_orig_d;
    logic                neg_q, neg_d;
    logic                bzero_q, bzero_d;
    logic [XLEN-1:0]     result_q, result_d;

    // Operand conditioning in IDLE
    logic            a_neg_in, b_neg_in;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            early_out;

    // Iteration datapath; acc_q holds {hi, lo} for multiply and {remainder, quotient} for divide
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_next;

    // FIX stage
    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   quo, rem, fix_val;

    always_comb begin
        a_neg_in = a[XLEN-1] & ((funct3 == F_MULH) | (funct3 == F_MULHSU) |
                                (funct3 == F_DIV)  | (funct3 == F_REM));
        b_neg_in = b[XLEN-1] & ((funct3 == F_MULH) | (funct3 == F_DIV) | (funct3 == F_REM));
        a_mag    = a_neg_in ? (~a + 1'b1) : a;
        b_mag    = b_neg_in ? (~b + 1'b1) : b;
`ifdef MD_EARLY_OUT_EN
        early_out = (a == '0) | (b == '0);
`else
        early_out = 1'b0;
`endif
    end

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        if (div_diff[XLEN])
            div_next = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        else
            div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end

    always_comb begin
        prod_signed = neg_q ? (~acc_q + 1'b1) : acc_q;
        quo         = acc_q[XLEN-1:0];
        rem         = acc_q[2*XLEN-1:XLEN];
        fix_val     = '0;
        case (op_q)
            F_MUL:                      fix_val = prod_signed[XLEN-1:0];
            F_MULH, F_MULHSU, F_MULHU:  fix_val = prod_signed[2*XLEN-1:XLEN];
            F_DIV, F_DIVU:              fix_val = bzero_q ? '1 : (neg_q ? (~quo + 1'b1) : quo);
            F_REM, F_REMU:              fix_val = bzero_q ? a_orig_q : (neg_q ? (~rem + 1'b1) : rem);
            default:                    fix_val = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        rd_d     = rd_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        a_orig_d = a_orig_q;
        neg_d    = neg_q;
        bzero_d  = bzero_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d     = funct3;
                    rd_d     = rd_in;
                    opb_d    = b_mag;
                    a_orig_d = a;
                    bzero_d  = (b == '0);
                    neg_d    = (funct3 == F_REM) ? a_neg_in : (a_neg_in ^ b_neg_in);
                    cnt_d    = '0;
                    if (early_out) begin
                        // Zero product, zero quotient/remainder, or an override applied in FIX
                        acc_d   = '0;
                        state_d = S_FIX;
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, a_mag};
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                acc_d = op_q[2] ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {CNT_W{1'b1}})
                    state_d = S_FIX;
            end
            S_FIX: begin
                result_d = fix_val;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_MD) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            a_orig_q <= '0;
            neg_q    <= 1'b0;
            bzero_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            a_orig_q <= a_orig_d;
            neg_q    <= neg_d;
            bzero_q  <= bzero_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign rd_out = rd_q;

endmodule
